rr_select_mux: RTL and testbench

Parametrised N-input, registered selector with valid/ready handshakes that replaces the combinational 3-to-1 select in the pipeline. It selects one input channel per transfer, either by an explicit select code or by round-robin arbitration. The selected word is captured in a single output register, so a 2-input to 8-input select point can sit between pipeline stages without adding a combinational path. Typical use: register-index and operand-source selection feeding the register file or forwarding logic.

---
 rtl/rr_select_mux.sv | 102 ++++++++++
 tb/tb_rr_select_mux.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/rr_select_mux.sv
// Registered N-to-1 selector: explicit select code or round-robin arbitration.
// Latency: 1 cycle from input transfer to out_data/out_valid; 1 word/cycle throughput.
// Backpressure: in_ready is all zero while the output word is held (out_valid && !out_ready).
module rr_select_mux #(
    parameter int WIDTH  = 5,
    parameter int NUM_IN = 3,
    parameter int SEL_W  = $clog2(NUM_IN)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    input  logic [NUM_IN-1:0]       in_valid,
    output logic [NUM_IN-1:0]       in_ready,
    input  logic                    mode,
    input  logic [SEL_W-1:0]        sel,
    output logic [WIDTH-1:0]        out_data,
    output logic [SEL_W-1:0]        out_src,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    sel_err
);

    logic [SEL_W-1:0] ptr;
    logic [SEL_W-1:0] gnt_idx;
    logic [SEL_W-1:0] gnt_nxt;
    logic [WIDTH-1:0] gnt_word;
    logic             gnt_vld;
    logic             sel_bad;
    logic             slot_free;
    logic             take;
    int               idx;

    // Grant search; the nested constant-index loops keep every vector select in range.
    always_comb begin
        gnt_vld  = 1'b0;
        gnt_idx  = '0;
        gnt_nxt  = '0;
        gnt_word = '0;
        sel_bad  = 1'b0;
        idx      = 0;
        if (!mode) begin
            sel_bad = (int'(sel) >= NUM_IN);
            for (int i = 0; i < NUM_IN; i++) begin
                if (int'(sel) == i && in_valid[i]) begin
                    gnt_vld  = 1'b1;
                    gnt_idx  = SEL_W'(i);
                    gnt_word = in_data[i*WIDTH +: WIDTH];
                end
            end
        end else begin
            for (int k = 0; k < NUM_IN; k++) begin
                idx = int'(ptr) + k;
                if (idx >= NUM_IN) begin
                    idx = idx - NUM_IN;
                end
                for (int i = 0; i < NUM_IN; i++) begin
                    if (!gnt_vld && i == idx && in_valid[i]) begin
                        gnt_vld  = 1'b1;
                        gnt_idx  = SEL_W'(i);
                        gnt_nxt  = SEL_W'((i + 1) % NUM_IN);
                        gnt_word = in_data[i*WIDTH +: WIDTH];
                    end
                end
            end
        end
    end

    assign slot_free = !out_valid || out_ready;
    assign take      = rst_n && gnt_vld && slot_free;

    always_comb begin
        in_ready = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            in_ready[i] = take && (gnt_idx == SEL_W'(i));
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_data  <= '0;
            out_src   <= '0;
            out_valid <= 1'b0;
            ptr       <= '0;
            sel_err   <= 1'b0;
        end else begin
            if (sel_bad) begin
                sel_err <= 1'b1;
            end
            if (take) begin
                out_data  <= gnt_word;
                out_src   <= gnt_idx;
                out_valid <= 1'b1;
                if (mode) begin
                    ptr <= gnt_nxt;
                end
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_rr_select_mux.sv
// Directed bench for rr_select_mux (3x5-bit and 8x32-bit instances).
// Expected words are queued when an input transfer is predicted and popped at the output transfer.
module tb_rr_select_mux;

    typedef struct packed {
        logic [4:0] d;
        logic [1:0] s;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [14:0] in_data;
    logic [2:0]  in_valid;
    logic [2:0]  in_ready;
    logic        mode;
    logic [1:0]  sel;
    logic [4:0]  out_data;
    logic [1:0]  out_src;
    logic        out_valid;
    logic        out_ready;
    logic        sel_err;

    logic [255:0] in_data8;
    logic [7:0]   in_valid8;
    logic [7:0]   in_ready8;
    logic         mode8;
    logic [2:0]   sel8;
    logic [31:0]  out_data8;
    logic [2:0]   out_src8;
    logic         out_valid8;
    logic         out_ready8;
    logic         sel_err8;

    int   errors = 0;
    int   checks = 0;
    exp_t q[$];
    logic m_valid = 1'b0;
    logic m_err   = 1'b0;
    logic [4:0] ch [3] = '{5'h01, 5'h0A, 5'h1F};

    always #5 clk = ~clk;

    rr_select_mux #(.WIDTH(5), .NUM_IN(3)) dut (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .mode(mode), .sel(sel), .out_data(out_data),
        .out_src(out_src), .out_valid(out_valid), .out_ready(out_ready),
        .sel_err(sel_err)
    );

    rr_select_mux #(.WIDTH(32), .NUM_IN(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_data(in_data8), .in_valid(in_valid8),
        .in_ready(in_ready8), .mode(mode8), .sel(sel8), .out_data(out_data8),
        .out_src(out_src8), .out_valid(out_valid8), .out_ready(out_ready8),
        .sel_err(sel_err8)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One cycle with inputs already driven; acc is the channel expected to transfer, or -1.
    task automatic step(input string tag, input logic [2:0] exp_rdy, input int acc);
        exp_t e;
        #1;
        chk({tag, ".in_ready"}, 64'(in_ready), 64'(exp_rdy));
        if (m_valid && out_ready && q.size() > 0) begin
            e = q.pop_front();
            chk({tag, ".out_data"}, 64'(out_data), 64'(e.d));
            chk({tag, ".out_src"}, 64'(out_src), 64'(e.s));
        end
        if (acc >= 0) begin
            e.d = ch[acc];
            e.s = acc[1:0];
            q.push_back(e);
            m_valid = 1'b1;
        end else if (out_ready) begin
            m_valid = 1'b0;
        end
        @(posedge clk);
        #1;
        chk({tag, ".out_valid"}, 64'(out_valid), 64'(m_valid));
        chk({tag, ".sel_err"}, 64'(sel_err), 64'(m_err));
        if (m_valid && !out_ready && q.size() > 0) begin
            chk({tag, ".held_data"}, 64'(out_data), 64'(q[0].d));
            chk({tag, ".held_src"}, 64'(out_src), 64'(q[0].s));
        end
    endtask

    initial begin
        rst_n      = 1'b0;
        in_data    = {5'h1F, 5'h0A, 5'h01};
        in_valid   = 3'b111;
        mode       = 1'b1;
        sel        = 2'd0;
        out_ready  = 1'b1;
        for (int i = 0; i < 8; i++) begin
            in_data8[i*32 +: 32] = 32'hC0DE_0000 + 32'(i);
        end
        in_valid8  = 8'h00;
        mode8      = 1'b1;
        sel8       = 3'd0;
        out_ready8 = 1'b1;

        // Reset: in_ready held low, registers cleared.
        #1;
        chk("rst.in_ready", 64'(in_ready), 64'(3'b000));
        repeat (2) @(posedge clk);
        #1;
        chk("rst.in_ready2", 64'(in_ready), 64'(3'b000));
        chk("rst.out_valid", 64'(out_valid), 64'(1'b0));
        chk("rst.out_data", 64'(out_data), 64'(5'h00));
        chk("rst.out_src", 64'(out_src), 64'(2'd0));
        chk("rst.sel_err", 64'(sel_err), 64'(1'b0));
        rst_n    = 1'b1;
        in_valid = 3'b000;
        step("idle", 3'b000, -1);

        // Explicit select of channel 1 for three cycles.
        mode = 1'b0; sel = 2'd1; in_valid = 3'b111;
        step("sel1_a", 3'b010, 1);
        step("sel1_b", 3'b010, 1);
        step("sel1_c", 3'b010, 1);
        in_valid = 3'b000;
        step("sel1_flush", 3'b000, -1);

        // Out-of-range select: no grant, sticky error.
        sel = 2'd3; in_valid = 3'b111; m_err = 1'b1;
        step("sel3_a", 3'b000, -1);
        step("sel3_b", 3'b000, -1);
        sel = 2'd2;
        step("sel2", 3'b100, 2);
        in_valid = 3'b000;
        step("sel2_flush", 3'b000, -1);

        // Round-robin: 0,1,2,0,1,2 then 0,2,0,2 with no bubbles.
        mode = 1'b1; in_valid = 3'b111;
        step("rr0", 3'b001, 0);
        step("rr1", 3'b010, 1);
        step("rr2", 3'b100, 2);
        step("rr3", 3'b001, 0);
        step("rr4", 3'b010, 1);
        step("rr5", 3'b100, 2);
        in_valid = 3'b101;
        step("rr6", 3'b001, 0);
        step("rr7", 3'b100, 2);
        step("rr8", 3'b001, 0);
        step("rr9", 3'b100, 2);

        // Backpressure while holding 5'h0A; pointer must stay at 2.
        in_valid = 3'b111;
        step("bp_pre0", 3'b001, 0);
        step("bp_pre1", 3'b010, 1);
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step("bp_hold", 3'b000, -1);
        end
        chk("bp.held_0A", 64'(out_data), 64'(5'h0A));
        out_ready = 1'b1;
        step("bp_release", 3'b100, 2);
        step("bp_next0", 3'b001, 0);
        step("bp_next1", 3'b010, 1);

        // Reset mid-operation: out_valid=1, ptr=2, sel_err=1.
        rst_n = 1'b0;
        #1;
        chk("mrst.in_ready", 64'(in_ready), 64'(3'b000));
        @(posedge clk);
        #1;
        chk("mrst.out_valid", 64'(out_valid), 64'(1'b0));
        chk("mrst.out_data", 64'(out_data), 64'(5'h00));
        chk("mrst.out_src", 64'(out_src), 64'(2'd0));
        chk("mrst.sel_err", 64'(sel_err), 64'(1'b0));
        q.delete();
        m_valid = 1'b0;
        m_err   = 1'b0;
        rst_n   = 1'b1;
        step("mrst_first", 3'b001, 0);
        in_valid = 3'b000;
        step("mrst_flush", 3'b000, -1);

        // Wide instance: ptr brought to 7 via channel 6, then 7,0,7.
        in_valid8 = 8'h40;
        #1;
        chk("w.rdy6", 64'(in_ready8), 64'(8'h40));
        @(posedge clk);
        #1;
        chk("w.src6", 64'(out_src8), 64'(3'd6));
        in_valid8 = 8'h81;
        #1;
        chk("w.rdy7", 64'(in_ready8), 64'(8'h80));
        @(posedge clk);
        #1;
        chk("w.src7", 64'(out_src8), 64'(3'd7));
        chk("w.data7", 64'(out_data8), 64'(32'hC0DE_0007));
        #1;
        chk("w.rdy0", 64'(in_ready8), 64'(8'h01));
        @(posedge clk);
        #1;
        chk("w.src0", 64'(out_src8), 64'(3'd0));
        chk("w.data0", 64'(out_data8), 64'(32'hC0DE_0000));
        #1;
        chk("w.rdy7b", 64'(in_ready8), 64'(8'h80));
        @(posedge clk);
        #1;
        chk("w.src7b", 64'(out_src8), 64'(3'd7));
        chk("w.valid", 64'(out_valid8), 64'(1'b1));
        chk("w.sel_err", 64'(sel_err8), 64'(1'b0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
